// File: rtl/bp_be_fe_cmd_issuer.sv
// Upstream producer for the BE->FE command queue.
// Arbitrates redirect, ITLB-fill and I$-fence requests into a single packed
// FE command per cycle. Handshakes are zero-latency: request, issue and yumi
// all resolve combinationally in the same cycle. Fences are serialised: a
// fence only enters an empty queue, after which all issue stalls until the
// FE reports that the fence has completed.
module bp_be_fe_cmd_issuer #(
  parameter int vaddr_width_p   = 39,
  parameter int payload_width_p = 64,
  parameter int cnt_width_p     = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic                         redirect_v_i,
  input  logic [vaddr_width_p-1:0]     redirect_pc_i,
  output logic                         redirect_yumi_o,

  input  logic                         fill_v_i,
  input  logic [payload_width_p-1:0]   fill_data_i,
  output logic                         fill_yumi_o,

  input  logic                         fence_v_i,
  output logic                         fence_yumi_o,

  output logic [payload_width_p+2:0]   fe_cmd_o,
  output logic                         fe_cmd_v_o,
  input  logic                         queue_full_i,
  input  logic                         queue_empty_i,

  input  logic                         fe_fence_done_i,
  output logic                         busy_o,
  output logic [cnt_width_p-1:0]       issued_cnt_o
);

  // Opcode encodings in the top three bits of the FE command.
  typedef enum logic [2:0] {
    op_redirect     = 3'd0,
    op_itlb_fill    = 3'd1,
    op_icache_fence = 3'd2
  } fe_opcode_e;

  // READY      : normal arbitration.
  // FENCE_WAIT : a fence is pending until the queue empties; redirects may
  //              still overtake it, fills may not.
  // DRAIN      : a fence is in flight; nothing issues until the FE is done.
  typedef enum logic [1:0] {
    st_ready      = 2'd0,
    st_fence_wait = 2'd1,
    st_drain      = 2'd2
  } state_e;

  localparam logic [cnt_width_p-1:0] cnt_one = cnt_width_p'(1);

  state_e state_q, state_d;

  // Raw grants before reset gating; at most one of these is set.
  logic grant_redirect;
  logic grant_fill;
  logic grant_fence;
  logic any_grant;

  logic [payload_width_p-1:0] pc_ext;

  // State register: only the FSM state lives here.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; combinational blocks below use blocking (=).
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= st_ready;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant decode: pick the single request that may issue this cycle.
  // NOTE: every signal written in an always_comb gets a default at the top
  // of the block so that no path leaves it unassigned (no latch).
  always_comb begin
    grant_redirect = 1'b0;
    grant_fill     = 1'b0;
    grant_fence    = 1'b0;
    unique case (state_q)
      st_ready: begin
        if (!queue_full_i) begin
          if (redirect_v_i) begin
            grant_redirect = 1'b1;
          end else if (fill_v_i) begin
            grant_fill = 1'b1;
          end else if (fence_v_i && queue_empty_i) begin
            grant_fence = 1'b1;
          end
        end
      end
      st_fence_wait: begin
        // Fills are held back so they cannot slip in ahead of the fence.
        if (!queue_full_i) begin
          if (redirect_v_i) begin
            grant_redirect = 1'b1;
          end else if (fence_v_i && queue_empty_i) begin
            grant_fence = 1'b1;
          end
        end
      end
      st_drain: begin
        // Fence in flight: issue nothing.
      end
      default: begin
      end
    endcase
  end

  assign any_grant = grant_redirect | grant_fill | grant_fence;

  // Next-state logic for the fence serialisation FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      st_ready: begin
        // A fence that wins arbitration either enters an empty queue now or
        // waits for the queue to drain first.
        if (fence_v_i && !redirect_v_i && !fill_v_i) begin
          state_d = grant_fence ? st_drain : st_fence_wait;
        end
      end
      st_fence_wait: begin
        if (!fence_v_i) begin
          state_d = st_ready;
        end else if (grant_fence) begin
          state_d = st_drain;
        end
      end
      st_drain: begin
        if (fe_fence_done_i) begin
          state_d = st_ready;
        end
      end
      default: begin
        state_d = st_ready;
      end
    endcase
  end

  // Output logic: yumis, enqueue strobe and the packed command word.
  always_comb begin
    pc_ext                     = '0;
    pc_ext[vaddr_width_p-1:0]  = redirect_pc_i;

    redirect_yumi_o = reset_n_i & grant_redirect;
    fill_yumi_o     = reset_n_i & grant_fill;
    fence_yumi_o    = reset_n_i & grant_fence;
    fe_cmd_v_o      = reset_n_i & any_grant;
    busy_o          = reset_n_i & (state_q != st_ready);

    fe_cmd_o = '0;
    if (fe_cmd_v_o) begin
      if (grant_redirect) begin
        fe_cmd_o = {op_redirect, pc_ext};
      end else if (grant_fill) begin
        fe_cmd_o = {op_itlb_fill, fill_data_i};
      end else begin
        fe_cmd_o = {op_icache_fence, {payload_width_p{1'b0}}};
      end
    end
  end

  // Issued-command counter: one increment per enqueue, wrapping naturally.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      issued_cnt_o <= '0;
    end else if (fe_cmd_v_o) begin
      issued_cnt_o <= issued_cnt_o + cnt_one;
    end
  end

  // The queue can never report full and empty at once.
  a_full_empty_exclusive : assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
      !(queue_full_i && queue_empty_i)
  );

  // A yumi is always accompanied by an enqueue, and nothing enqueues into a full queue.
  a_yumi_implies_v : assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
      (redirect_yumi_o | fill_yumi_o | fence_yumi_o) |-> fe_cmd_v_o
  );

  a_no_issue_when_full : assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
      queue_full_i |-> !fe_cmd_v_o
  );

endmodule
